// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//   Pipeline hazard controller for the 5-stage MIPS core. It detects RAW data
//   hazards between the ID-stage sources and the EX/MEM destinations, and
//   taken control transfers resolved in EX. A small counter-driven FSM then
//   sequences multi-cycle data stalls and control flushes.
//
//   Outputs are Mealy: they depend on the current state and on this cycle's
//   detection, so the first stall/flush cycle takes effect in the same cycle
//   the hazard is seen.
//
// Parameters
//   EX_PENALTY    stall cycles when the producer is in EX        (1..15)
//   MEM_PENALTY   stall cycles when the producer is in MEM       (1..15)
//   CTRL_PENALTY  flush cycles after a taken branch/jump         (1..15)
//   LOAD_PENALTY  load-use stall cycles, forwarding build only   (1..15)
//
// Build option
//   FORWARDING_EN  defined   : EX/MEM forwarding exists, so only a load in EX
//                              causes a stall (LOAD_PENALTY cycles) and the
//                              MEM-stage producer never stalls.
//                  undefined : full interlock (default).
//
// Ports
//   CLK, RST                    clock (rising edge), synchronous active-high reset
//   RegWrite2, MemRead2,
//   WriteReg_addr2              EX-stage producer info
//   RegWrite3, WriteReg_addr3   MEM-stage producer info
//   Read1, Read2, Use1, Use2    ID-stage source registers and their use flags
//   Branch2, JtoPC2             taken branch / jump in EX
//   PCWrite, IFIDWrite          PC and IF/ID load enables
//   IFIDFlush, IDEXFlush        pipeline register clears
//   Stall                       a data stall is active this cycle
//   State                       FSM state: 00 IDLE, 01 DSTALL, 10 CFLUSH
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int unsigned EX_PENALTY   = 2,
  parameter int unsigned MEM_PENALTY  = 1,
  parameter int unsigned CTRL_PENALTY = 1,
  parameter int unsigned LOAD_PENALTY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RegWrite2,
  input  logic       MemRead2,
  input  logic [4:0] WriteReg_addr2,
  input  logic       RegWrite3,
  input  logic [4:0] WriteReg_addr3,
  input  logic [4:0] Read1,
  input  logic [4:0] Read2,
  input  logic       Use1,
  input  logic       Use2,
  input  logic       Branch2,
  input  logic       JtoPC2,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       Stall,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DSTALL = 2'b01,
    S_CFLUSH = 2'b10
  } state_t;

  // Counter reload values: the first penalty cycle happens in IDLE, so the
  // counter only covers the remaining P-1 cycles.
  localparam logic [3:0] EX_LD   = 4'(EX_PENALTY - 1);
  localparam logic [3:0] MEM_LD  = 4'(MEM_PENALTY - 1);
  localparam logic [3:0] CTRL_LD = 4'(CTRL_PENALTY - 1);
  localparam logic [3:0] LOAD_LD = 4'(LOAD_PENALTY - 1);

  localparam bit EX_MULTI   = (EX_PENALTY > 1);
  localparam bit MEM_MULTI  = (MEM_PENALTY > 1);
  localparam bit CTRL_MULTI = (CTRL_PENALTY > 1);
  localparam bit LOAD_MULTI = (LOAD_PENALTY > 1);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic       w_ex_match;
  logic       w_mem_match;
  logic       w_dh_ex;
  logic       w_dh_mem;
  logic       w_data_hz;
  logic       w_data_multi;
  logic [3:0] w_data_ld;
  logic       w_ctrl;
  logic       w_unused;

  // Register $0 is hardwired to zero, so a write to it never creates a hazard.
  assign w_ex_match  = RegWrite2 && (WriteReg_addr2 != 5'd0) &&
                       ((Use1 && (WriteReg_addr2 == Read1)) ||
                        (Use2 && (WriteReg_addr2 == Read2)));
  assign w_mem_match = RegWrite3 && (WriteReg_addr3 != 5'd0) &&
                       ((Use1 && (WriteReg_addr3 == Read1)) ||
                        (Use2 && (WriteReg_addr3 == Read2)));

`ifdef FORWARDING_EN
  // With forwarding only a load in EX cannot be bypassed in time.
  assign w_dh_ex      = w_ex_match && MemRead2;
  assign w_dh_mem     = 1'b0;
  assign w_data_multi = LOAD_MULTI;
  assign w_data_ld    = LOAD_LD;
  assign w_unused     = w_mem_match ^ EX_MULTI ^ MEM_MULTI ^ (|EX_LD) ^ (|MEM_LD);
`else
  assign w_dh_ex      = w_ex_match;
  assign w_dh_mem     = w_mem_match;
  // EX producer has priority: it is the younger, longer-latency dependency.
  assign w_data_multi = w_dh_ex ? EX_MULTI : MEM_MULTI;
  assign w_data_ld    = w_dh_ex ? EX_LD : MEM_LD;
  assign w_unused     = MemRead2 ^ LOAD_MULTI ^ (|LOAD_LD);
`endif

  assign w_data_hz = w_dh_ex || w_dh_mem;
  assign w_ctrl    = Branch2 || JtoPC2;

  // ---------------------------------------------------------------------------
  // State / counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ctrl) begin
            if (CTRL_MULTI) begin
              r_state <= S_CFLUSH;
              r_cnt   <= CTRL_LD;
            end
          end else if (w_data_hz && w_data_multi) begin
            r_state <= S_DSTALL;
            r_cnt   <= w_data_ld;
          end
        end
        S_DSTALL: begin
          // A control transfer squashes the stalled instruction, so the stall
          // is abandoned and the flush sequence starts as it would from IDLE.
          if (w_ctrl) begin
            if (CTRL_MULTI) begin
              r_state <= S_CFLUSH;
              r_cnt   <= CTRL_LD;
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= 4'd0;
            end
          end else if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CFLUSH: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Mealy outputs
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    A_NORMAL,
    A_STALL,
    A_FLUSH,
    A_RESET
  } action_t;

  action_t w_action;

  always_comb begin
    w_action = A_NORMAL;
    if (RST) begin
      w_action = A_RESET;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ctrl)         w_action = A_FLUSH;
          else if (w_data_hz) w_action = A_STALL;
          else                w_action = A_NORMAL;
        end
        S_DSTALL: w_action = w_ctrl ? A_FLUSH : A_STALL;
        S_CFLUSH: w_action = A_FLUSH;
        default:  w_action = A_NORMAL;
      endcase
    end
  end

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    Stall     = 1'b0;
    case (w_action)
      A_STALL: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
        Stall     = 1'b1;
      end
      A_FLUSH: begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end
      A_RESET: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end
      default: begin
        PCWrite = 1'b1;
      end
    endcase
  end

  // State reads as IDLE while reset is held, before the first edge clears it.
  assign State = RST ? S_IDLE : r_state;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  // Output vector layout: {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stall, State}
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_RST   = 5'b00110;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic       RegWrite2, MemRead2, RegWrite3, Use1, Use2, Branch2, JtoPC2;
  logic [4:0] WriteReg_addr2, WriteReg_addr3, Read1, Read2;

  // Instance A: default penalties (EX 2, MEM 1, CTRL 1, LOAD 1)
  logic       pcw_a, ifw_a, iff_a, ief_a, stl_a;
  logic [1:0] st_a;
  // Instance B: longer penalties (EX 3, MEM 2, CTRL 2, LOAD 2)
  logic       pcw_b, ifw_b, iff_b, ief_b, stl_b;
  logic [1:0] st_b;

  hazard_sequencer dut_a (
    .CLK(CLK), .RST(RST),
    .RegWrite2(RegWrite2), .MemRead2(MemRead2), .WriteReg_addr2(WriteReg_addr2),
    .RegWrite3(RegWrite3), .WriteReg_addr3(WriteReg_addr3),
    .Read1(Read1), .Read2(Read2), .Use1(Use1), .Use2(Use2),
    .Branch2(Branch2), .JtoPC2(JtoPC2),
    .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFIDFlush(iff_a), .IDEXFlush(ief_a),
    .Stall(stl_a), .State(st_a)
  );

  hazard_sequencer #(
    .EX_PENALTY(3), .MEM_PENALTY(2), .CTRL_PENALTY(2), .LOAD_PENALTY(2)
  ) dut_b (
    .CLK(CLK), .RST(RST),
    .RegWrite2(RegWrite2), .MemRead2(MemRead2), .WriteReg_addr2(WriteReg_addr2),
    .RegWrite3(RegWrite3), .WriteReg_addr3(WriteReg_addr3),
    .Read1(Read1), .Read2(Read2), .Use1(Use1), .Use2(Use2),
    .Branch2(Branch2), .JtoPC2(JtoPC2),
    .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFIDFlush(iff_b), .IDEXFlush(ief_b),
    .Stall(stl_b), .State(st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [6:0] exp_q_a[$];
  logic [6:0] exp_q_b[$];
  int tests  = 0;
  int failed = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clr_inputs();
    RegWrite2 = 1'b0; MemRead2 = 1'b0; WriteReg_addr2 = 5'd0;
    RegWrite3 = 1'b0; WriteReg_addr3 = 5'd0;
    Read1 = 5'd0; Read2 = 5'd0; Use1 = 1'b0; Use2 = 1'b0;
    Branch2 = 1'b0; JtoPC2 = 1'b0;
  endtask

  task automatic ex_hazard(input logic [4:0] r);
    RegWrite2 = 1'b1; WriteReg_addr2 = r; Read1 = r; Use1 = 1'b1;
  endtask

  // One clock cycle: inputs already driven just after the rising edge; the
  // expected outputs of both instances are queued, then checked mid-cycle.
  task automatic cyc(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    logic [6:0] e;
    logic [6:0] o;
    exp_q_a.push_back(ea);
    exp_q_b.push_back(eb);
    @(negedge CLK);
    e = exp_q_a.pop_front();
    o = {pcw_a, ifw_a, iff_a, ief_a, stl_a, st_a};
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s/A observed=%b expected=%b", tag, o, e);
    end
    e = exp_q_b.pop_front();
    o = {pcw_b, ifw_b, iff_b, ief_b, stl_b, st_b};
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s/B observed=%b expected=%b", tag, o, e);
    end
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    clr_inputs();
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Reset state, with a hazard and a branch present to show they are masked
    cyc("rst0", {O_RST, S0}, {O_RST, S0});
    ex_hazard(5'd5); Branch2 = 1'b1;
    cyc("rst1", {O_RST, S0}, {O_RST, S0});
    clr_inputs(); RST = 1'b0;
    cyc("idle", {O_NORM, S0}, {O_NORM, S0});

`ifdef FORWARDING_EN
    // Non-load producer is forwarded: no stall
    RegWrite2 = 1'b1; WriteReg_addr2 = 5'd7; Read2 = 5'd7; Use2 = 1'b1;
    cyc("fwd_alu", {O_NORM, S0}, {O_NORM, S0});
    // Load-use: A stalls 1 cycle, B stalls 2
    MemRead2 = 1'b1;
    cyc("fwd_ld0", {O_STALL, S0}, {O_STALL, S0});
    clr_inputs();
    cyc("fwd_ld1", {O_NORM, S0}, {O_STALL, S1});
    cyc("fwd_ld2", {O_NORM, S0}, {O_NORM, S0});
    // MEM producer never stalls with forwarding
    RegWrite3 = 1'b1; WriteReg_addr3 = 5'd9; Read2 = 5'd9; Use2 = 1'b1;
    cyc("fwd_mem", {O_NORM, S0}, {O_NORM, S0});
    clr_inputs();
    // Branch still flushes
    Branch2 = 1'b1;
    cyc("fwd_br0", {O_FLUSH, S0}, {O_FLUSH, S0});
    clr_inputs();
    cyc("fwd_br1", {O_NORM, S0}, {O_FLUSH, S2});
    cyc("fwd_br2", {O_NORM, S0}, {O_NORM, S0});
`else
    // EX RAW hazard on Read1: A stalls 2 cycles, B 3; DSTALL ignores inputs
    ex_hazard(5'd5);
    cyc("ex0", {O_STALL, S0}, {O_STALL, S0});
    cyc("ex1", {O_STALL, S1}, {O_STALL, S1});
    clr_inputs();
    cyc("ex2", {O_NORM, S0}, {O_STALL, S1});
    cyc("ex3", {O_NORM, S0}, {O_NORM, S0});

    // Register $0 never hazards
    ex_hazard(5'd0);
    cyc("zero", {O_NORM, S0}, {O_NORM, S0});
    // Matching address but source not used
    ex_hazard(5'd5); Use1 = 1'b0;
    cyc("nouse", {O_NORM, S0}, {O_NORM, S0});
    // Different registers
    RegWrite2 = 1'b1; WriteReg_addr2 = 5'd5; Read1 = 5'd6; Use1 = 1'b1;
    cyc("nomatch", {O_NORM, S0}, {O_NORM, S0});
    clr_inputs();

    // MEM hazard on Read2: A 1 cycle (stays IDLE), B 2 cycles
    RegWrite3 = 1'b1; WriteReg_addr3 = 5'd9; Read2 = 5'd9; Use2 = 1'b1;
    cyc("mem0", {O_STALL, S0}, {O_STALL, S0});
    clr_inputs();
    cyc("mem1", {O_NORM, S0}, {O_STALL, S1});
    cyc("mem2", {O_NORM, S0}, {O_NORM, S0});

    // EX and MEM together: EX penalty wins
    ex_hazard(5'd3); RegWrite3 = 1'b1; WriteReg_addr3 = 5'd4; Read2 = 5'd4; Use2 = 1'b1;
    cyc("prio0", {O_STALL, S0}, {O_STALL, S0});
    clr_inputs();
    cyc("prio1", {O_STALL, S1}, {O_STALL, S1});
    cyc("prio2", {O_NORM, S0}, {O_STALL, S1});
    cyc("prio3", {O_NORM, S0}, {O_NORM, S0});

    // Branch with simultaneous data hazard: ctrl wins; CFLUSH ignores hazards
    ex_hazard(5'd5); Branch2 = 1'b1;
    cyc("br0", {O_FLUSH, S0}, {O_FLUSH, S0});
    Branch2 = 1'b0;
    cyc("br1", {O_STALL, S0}, {O_FLUSH, S2});
    clr_inputs();
    cyc("br2", {O_STALL, S1}, {O_NORM, S0});
    cyc("br3", {O_NORM, S0}, {O_NORM, S0});

    // Jump in first DSTALL cycle aborts the stall
    ex_hazard(5'd8);
    cyc("jab0", {O_STALL, S0}, {O_STALL, S0});
    clr_inputs(); JtoPC2 = 1'b1;
    cyc("jab1", {O_FLUSH, S1}, {O_FLUSH, S1});
    clr_inputs();
    cyc("jab2", {O_NORM, S0}, {O_FLUSH, S2});
    cyc("jab3", {O_NORM, S0}, {O_NORM, S0});

    // Reset mid-stall (B has cnt=2) abandons it
    ex_hazard(5'd11);
    cyc("rst_ms0", {O_STALL, S0}, {O_STALL, S0});
    RST = 1'b1;
    cyc("rst_ms1", {O_RST, S0}, {O_RST, S0});
    RST = 1'b0; clr_inputs();
    cyc("rst_ms2", {O_NORM, S0}, {O_NORM, S0});

    // Reset mid-flush (B in CFLUSH) abandons it
    JtoPC2 = 1'b1;
    cyc("rst_mf0", {O_FLUSH, S0}, {O_FLUSH, S0});
    clr_inputs(); RST = 1'b1;
    cyc("rst_mf1", {O_RST, S0}, {O_RST, S0});
    RST = 1'b0;
    cyc("rst_mf2", {O_NORM, S0}, {O_NORM, S0});

    // Full interlock: non-load EX producer on Read2 still stalls
    RegWrite2 = 1'b1; MemRead2 = 1'b0; WriteReg_addr2 = 5'd7; Read2 = 5'd7; Use2 = 1'b1;
    cyc("ilk0", {O_STALL, S0}, {O_STALL, S0});
    clr_inputs();
    cyc("ilk1", {O_STALL, S1}, {O_STALL, S1});
    cyc("ilk2", {O_NORM, S0}, {O_STALL, S1});
    cyc("ilk3", {O_NORM, S0}, {O_NORM, S0});
`endif

    // Every queued expectation must have been consumed
    tests++;
    assert ((exp_q_a.size() + exp_q_b.size()) === 0) else begin
      failed++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q_a.size() + exp_q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
